// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch state encodings and timing derivation helpers
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    STOP  = 2'b11
  } sw_state_e;

  function automatic int calc_db_cyc(input int clk_hz, input int debounce_ms);
    return clk_hz / 1000 * debounce_ms;
  endfunction

  function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_key_debounce.sv
// rtl/stopwatch_key_debounce.sv - key synchroniser, debounce counter and press pulse
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = cnt_width(DB_CYC);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // The level flips only after DB_CYC consecutive synchronised samples differ from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_sequencer.sv
// rtl/stopwatch_sequencer.sv - stopwatch key conditioning, start/stop FSM and tick prescaler
// Optional lap/display-hold feature is built when STOPWATCH_LAP_EN is defined.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int TICK_HZ     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       key_load,
`ifdef STOPWATCH_LAP_EN
  input  logic       key_lap,
`endif
  output logic       cnt_clr,
  output logic       cnt_tick,
  output logic       cnt_load,
  output logic       running,
  output logic [1:0] state,
  output logic       disp_hold
);

  localparam int DB_CYC   = calc_db_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
  localparam int PW       = cnt_width(TICK_DIV);

  logic ev_start, ev_pause, ev_load;

  key_debounce #(.DB_CYC(DB_CYC)) u_start (.clk(clk), .rst(rst), .key(key_start), .press(ev_start));
  key_debounce #(.DB_CYC(DB_CYC)) u_pause (.clk(clk), .rst(rst), .key(key_pause), .press(ev_pause));
  key_debounce #(.DB_CYC(DB_CYC)) u_load  (.clk(clk), .rst(rst), .key(key_load),  .press(ev_load));

  sw_state_e     cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          clr_nxt, load_nxt, tick_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= IDLE;
      presc    <= '0;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      cnt_tick <= 1'b0;
    end else begin
      cur      <= nxt;
      presc    <= presc_nxt;
      cnt_clr  <= clr_nxt;
      cnt_load <= load_nxt;
      cnt_tick <= tick_nxt;
    end
  end

  always_comb begin
    nxt       = cur;
    clr_nxt   = 1'b0;
    load_nxt  = 1'b0;
    presc_nxt = '0;
    tick_nxt  = 1'b0;

    // Only the highest-priority event present in a cycle is considered.
    if (ev_start) begin
      case (cur)
        IDLE:        nxt = RUN;
        RUN, PAUSE:  nxt = STOP;
        default: begin
          nxt     = IDLE;
          clr_nxt = 1'b1;
        end
      endcase
    end else if (ev_pause) begin
      if (cur == RUN)        nxt = PAUSE;
      else if (cur == PAUSE) nxt = RUN;
    end else if (ev_load) begin
      load_nxt = (cur == IDLE);
    end

    // A wrap on the edge that leaves RUN is not reported, so ticks stay inside RUN.
    case (cur)
      RUN: begin
        if (nxt != STOP) begin
          if (presc == PW'(TICK_DIV - 1)) begin
            tick_nxt = (nxt == RUN);
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
      end
      PAUSE: begin
        if (nxt != STOP) presc_nxt = presc;
      end
      default: presc_nxt = '0;
    endcase
  end

  assign state   = cur;
  assign running = (cur == RUN);

`ifdef STOPWATCH_LAP_EN
  logic ev_lap, lap_act, hold_q;

  key_debounce #(.DB_CYC(DB_CYC)) u_lap (.clk(clk), .rst(rst), .key(key_lap), .press(ev_lap));

  assign lap_act = ev_lap && !(ev_start || ev_pause || ev_load) && (cur == RUN || cur == PAUSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                hold_q <= 1'b0;
    else if (nxt == IDLE)   hold_q <= 1'b0;
    else if (lap_act)       hold_q <= ~hold_q;
  end

  assign disp_hold = hold_q;
`else
  assign disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb/tb_stopwatch_sequencer.sv - scoreboard bench for stopwatch_sequencer (DB_CYC=4, TICK_DIV=10)
module tb_stopwatch_sequencer;

  localparam int K_TICK = 0;
  localparam int K_CLR  = 1;
  localparam int K_LOAD = 2;
  localparam int KEY_START = 0;
  localparam int KEY_PAUSE = 1;
  localparam int KEY_LOAD  = 2;
  localparam int KEY_LAP   = 3;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  typedef struct {
    int kind;
    int at;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start = 1'b0;
  logic       key_pause = 1'b0;
  logic       key_load  = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic       key_lap   = 1'b0;
`endif
  logic       cnt_clr, cnt_tick, cnt_load, running, disp_hold;
  logic [1:0] state;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  sb_item_t   sb[$];

  stopwatch_sequencer #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .TICK_HZ(100)) dut (
    .clk(clk),
    .rst(rst),
    .key_start(key_start),
    .key_pause(key_pause),
    .key_load(key_load),
`ifdef STOPWATCH_LAP_EN
    .key_lap(key_lap),
`endif
    .cnt_clr(cnt_clr),
    .cnt_tick(cnt_tick),
    .cnt_load(cnt_load),
    .running(running),
    .state(state),
    .disp_hold(disp_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    sb_item_t it;
    it.kind = kind;
    it.at   = at;
    sb.push_back(it);
  endtask

  task automatic set_key(input int which, input logic val);
    case (which)
      KEY_START: key_start = val;
      KEY_PAUSE: key_pause = val;
      KEY_LOAD:  key_load  = val;
`ifdef STOPWATCH_LAP_EN
      KEY_LAP:   key_lap   = val;
`endif
      default: ;
    endcase
  endtask

  task automatic press(input int which, input int len);
    set_key(which, 1'b1);
    repeat (len) @(negedge clk);
    set_key(which, 1'b0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Every output pulse must match the next scheduled expectation in kind and cycle.
  always @(negedge clk) begin
    sb_item_t it;
    int       kind;
    if (!rst && (cnt_tick || cnt_clr || cnt_load)) begin
      kind = cnt_clr ? K_CLR : (cnt_load ? K_LOAD : K_TICK);
      if (cnt_tick) check("tick_in_run", running, 1);
      if (sb.size() == 0) begin
        check("pulse_unexpected", {29'd0, cnt_clr, cnt_load, cnt_tick}, 0);
      end else begin
        it = sb.pop_front();
        check("pulse_kind", kind, it.kind);
        check("pulse_cycle", cyc, it.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int t0, e, p, r, s, i, l, e2, s2, i2, r0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_running", running, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_tick", cnt_tick, 0);
    check("rst_load", cnt_load, 0);
    check("rst_hold", disp_hold, 0);
    rst = 1'b0;
    @(negedge clk);

    press(KEY_START, 3);
    repeat (20) @(negedge clk);
    check("short_press_idle", state, 0);
    for (int k = 0; k < 4; k++) begin
      key_start = 1'b1;
      repeat (2) @(negedge clk);
      key_start = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("bounce_idle", state, 0);

    // Start, pause at prescaler 6, resume, stop, clear, load.
    t0 = cyc;
    e  = t0 + 7;
    p  = e + 36;
    r  = p + 50;
    s  = r + 20;
    i  = s + 27;
    l  = i + 20;
    push(K_TICK, e + 10);
    push(K_TICK, e + 20);
    push(K_TICK, e + 30);
    push(K_TICK, r + 4);
    push(K_TICK, r + 14);
    push(K_CLR, i);
    push(K_LOAD, l);
    press(KEY_START, 6);
    wait_until(e - 1);
    check("start_latency_idle", state, 0);
    wait_until(e);
    check("start_run", state, 1);
    check("start_running", running, 1);
    wait_until(p - 7);
    press(KEY_PAUSE, 6);
    wait_until(p);
    check("pause_state", state, 2);
    check("pause_running", running, 0);
    wait_until(r - 7);
    press(KEY_PAUSE, 6);
    wait_until(r);
    check("resume_state", state, 1);
    wait_until(s - 7);
    press(KEY_START, 6);
    wait_until(s);
    check("stop_state", state, 3);
    wait_until(i - 7);
    press(KEY_START, 6);
    wait_until(i);
    check("clear_idle", state, 0);
    wait_until(l - 7);
    press(KEY_LOAD, 6);
    wait_until(l);
    check("load_idle", state, 0);
    wait_until(l + 10);

    // Load ignored in RUN; start and pause together act as start.
    e2 = cyc + 7;
    s2 = e2 + 30;
    i2 = s2 + 20;
    push(K_TICK, e2 + 10);
    push(K_TICK, e2 + 20);
    push(K_CLR, i2);
    press(KEY_START, 6);
    wait_until(e2 + 13);
    press(KEY_LOAD, 6);
    wait_until(e2 + 21);
    check("load_in_run_ignored", state, 1);
    wait_until(s2 - 7);
    key_start = 1'b1;
    key_pause = 1'b1;
    repeat (6) @(negedge clk);
    key_start = 1'b0;
    key_pause = 1'b0;
    wait_until(s2);
    check("start_beats_pause", state, 3);
    wait_until(i2 - 7);
    press(KEY_START, 6);
    wait_until(i2);
    check("second_clear_idle", state, 0);
    wait_until(i2 + 10);

    // Asynchronous reset mid-prescale, then a key held through reset release.
    t0 = cyc;
    press(KEY_START, 6);
    wait_until(t0 + 12);
    check("pre_reset_run", state, 1);
    rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_running", running, 0);
    check("async_rst_pulses", {cnt_clr, cnt_tick, cnt_load}, 0);
    check("async_rst_hold", disp_hold, 0);
    key_start = 1'b1;
    repeat (3) @(negedge clk);
    r0 = cyc;
    for (int k = 1; k <= 5; k++) push(K_TICK, r0 + 7 + 10 * k);
    push(K_CLR, r0 + 87);
    rst = 1'b0;
    wait_until(r0 + 6);
    check("held_key_not_yet", state, 0);
    wait_until(r0 + 7);
    check("held_key_run", state, 1);
    wait_until(r0 + 10);
    key_start = 1'b0;
`ifdef STOPWATCH_LAP_EN
    press(KEY_LAP, 6);
`endif
    wait_until(r0 + 17);
    check("lap_hold_set", disp_hold, LAP);
    check("held_key_single_event", state, 1);
`ifdef STOPWATCH_LAP_EN
    wait_until(r0 + 30);
    press(KEY_LAP, 6);
`endif
    wait_until(r0 + 37);
    check("lap_hold_clear", disp_hold, 0);
`ifdef STOPWATCH_LAP_EN
    wait_until(r0 + 50);
    press(KEY_LAP, 6);
`endif
    wait_until(r0 + 57);
    check("lap_hold_set_again", disp_hold, LAP);
    wait_until(r0 + 60);
    press(KEY_START, 6);
    wait_until(r0 + 67);
    check("lap_stop_state", state, 3);
    check("lap_hold_kept_in_stop", disp_hold, LAP);
    wait_until(r0 + 80);
    press(KEY_START, 6);
    wait_until(r0 + 87);
    check("lap_idle_state", state, 0);
    check("lap_hold_cleared_idle", disp_hold, 0);
    wait_until(r0 + 100);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_sequencer.md
# stopwatch_sequencer

Synchronous control sequencer for the digital stopwatch. It conditions the raw start, pause and load keys with synchronisers and debouncers, and runs the start/stop/reset state machine. It also generates the counting tick, and drives the clear, count-enable and load controls of the time-counter datapath. It sits between the key pins and the BCD time counter and replaces all key-edge-clocked logic with single-clock logic.

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- DEBOUNCE_MS, 20: key stable time; DB_CYC = CLK_HZ/1000*DEBOUNCE_MS cycles.
- TICK_HZ, 100: count rate, 10 ms resolution; TICK_DIV = CLK_HZ/TICK_HZ cycles.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_start  in  1  raw start/stop key, active-high, asynchronous.
- key_pause  in  1  raw pause key, active-high, asynchronous.
- key_load  in  1  raw preset-load key, active-high, asynchronous.
- key_lap  in  1  raw lap key; present only with STOPWATCH_LAP_EN.
- cnt_clr  out  1  one-cycle pulse: clear time counter.
- cnt_tick  out  1  one-cycle pulse: counter increments by one.
- cnt_load  out  1  one-cycle pulse: counter loads preset.
- running  out  1  level: state is RUN.
- state  out  2  current FSM state.
- disp_hold  out  1  level: display freezes its last value (lap).

## Operation
- Key path: 2-FF synchroniser, then debouncer. The debounced level changes only after DB_CYC consecutive equal synchronised samples. A press event is a one-cycle pulse on the debounced 0->1 edge. Releases generate no event.
- FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, STOP=2'b11.
- start event: IDLE->RUN; RUN->STOP; PAUSE->STOP; STOP->IDLE, which asserts cnt_clr for one cycle.
- pause event: RUN->PAUSE and PAUSE->RUN. Ignored in IDLE and STOP.
- load event: accepted in IDLE only and pulses cnt_load; the state stays IDLE. Ignored in every other state.
- Simultaneous events in one cycle: start takes priority over pause, and pause over load. Only the highest-priority event acts; the others are dropped.
- Prescaler, width clog2(TICK_DIV):
  - increments only in RUN and holds its value in PAUSE, so phase is preserved across a pause;
  - is cleared in IDLE and STOP;
  - wraps at TICK_DIV-1, and cnt_tick pulses on that wrap cycle while in RUN.
- running = (state==RUN). cnt_tick is never asserted outside RUN.

## Timing
- Reset values:
  - state=IDLE;
  - cnt_clr, cnt_tick, cnt_load, running, disp_hold all 0;
  - debounced levels 0, prescaler 0.
- A key held through reset release produces exactly one event, DB_CYC+2 cycles later.
- Press latency from a stable raw high: 2 synchroniser cycles + DB_CYC debounce cycles give the event pulse. The state and output pulses update on the next edge.
- First cnt_tick arrives TICK_DIV cycles after entering RUN from IDLE.
- After a pause, the first tick arrives (TICK_DIV - held count) cycles after resume.
- Reset mid-operation: all outputs return to reset values asynchronously. Any pulse in flight is lost.
- Pulses are exactly one cycle wide. There are no back-to-back duplicates per key press.

## Configuration
- STOPWATCH_LAP_EN defined:
  - key_lap exists and has its own synchroniser/debouncer.
  - A lap event in RUN or PAUSE toggles disp_hold.
  - disp_hold is cleared on entry to IDLE; it holds its value in STOP.
  - A lap event is ignored in IDLE and STOP.
  - Lap has the lowest priority among simultaneous events.
- STOPWATCH_LAP_EN undefined: no key_lap port, and disp_hold is tied to 0.

## Structure
- Shared package stopwatch_pkg holds the state encodings (IDLE/RUN/PAUSE/STOP) and the DB_CYC/TICK_DIV derivation helpers. The time counter and display blocks use the same package.
- One sub-module: key_debounce (synchroniser + debounce counter + rising-edge pulse). It is instantiated three times, or four with lap enabled.

## Test plan
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=4 (DB_CYC=4) and TICK_HZ=100 (TICK_DIV=10).
- Reset then press start for 8 cycles -> one event; state IDLE->RUN. cnt_tick pulses every 10 cycles, the first exactly 10 cycles after entry.
- Start pulse shorter than 4 cycles, or bouncing every 2 cycles -> no event; state stays IDLE.
- RUN, pause at prescaler=6, hold 50 cycles, pause again -> no ticks while paused; first tick 4 cycles after resume.
- RUN -> start -> STOP (no ticks) -> start -> IDLE with a single cnt_clr pulse. Load in IDLE -> cnt_load pulse. Load in RUN -> ignored.
- Start and pause events in the same cycle while in RUN -> state STOP; pause dropped.
- rst asserted in RUN mid-prescale -> all outputs 0 and state IDLE immediately. Key held across reset -> one event 6 cycles after release of rst.
- With STOPWATCH_LAP_EN: lap in RUN -> disp_hold=1; lap again -> 0; STOP->IDLE clears it.
